// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit; each bit lasts 'prescale' clk cycles.
module uart_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     p_data,
   input  logic                      data_valid,
   input  logic                      par_en,
   input  logic                      par_typ,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tx_out,
   output logic                      busy
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                    state;
   logic [DATA_WIDTH-1:0]     shift_reg;
   logic                      par_en_q;
   logic                      parity_q;
   logic [PRESCALE_WIDTH-1:0] last_tick;
   logic [PRESCALE_WIDTH-1:0] tick_cnt;
   logic [BIT_CNT_W-1:0]      bit_cnt;
   logic                      bit_done;

   // last_tick holds P-1, so a bit ends when the tick counter reaches it
   assign bit_done = (tick_cnt == last_tick);

   // Whole transmitter in one registered FSM; tx_out and busy change on the
   // same edge as the state so no output lags its state by a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         par_en_q  <= 1'b0;
         parity_q  <= 1'b0;
         last_tick <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         tx_out    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_out   <= 1'b1;
               busy     <= 1'b0;
               tick_cnt <= '0;
               bit_cnt  <= '0;
               if (data_valid) begin
                  shift_reg <= p_data;
                  par_en_q  <= par_en;
                  parity_q  <= (^p_data) ^ par_typ;
                  last_tick <= (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
                  tx_out    <= 1'b0;
                  busy      <= 1'b1;
                  state     <= START;
               end
            end

            START: begin
               if (bit_done) begin
                  tick_cnt  <= '0;
                  tx_out    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  state     <= DATA;
               end else begin
                  tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
               end
            end

            DATA: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        tx_out <= parity_q;
                        state  <= PARITY;
                     end else begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                     tx_out    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end else begin
                  tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
               end
            end

            PARITY: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  tx_out   <= 1'b1;
                  state    <= STOP;
               end else begin
                  tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
               end
            end

            STOP: begin
               if (bit_done) begin
                  tick_cnt <= '0;
                  tx_out   <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tick_cnt <= tick_cnt + PRESCALE_WIDTH'(1);
               end
            end

            default: begin
               state    <= IDLE;
               tick_cnt <= '0;
               bit_cnt  <= '0;
               tx_out   <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes every frame cycle
// by cycle against a queue of expected frames pushed by the stimulus tasks.
module tb_uart_tx;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      int         p;
   } frame_t;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic [5:0] prescale;
   logic       tx_out;
   logic       busy;

   frame_t expQ[$];
   int     checkCount;
   int     failCount;
   int     framesLaunched;
   int     framesDone;

   uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Bounded wait for busy to reach a level, sampled on falling edges
   task automatic waitBusy(input logic level, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== level && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (busy !== level) checkOutput(tag, busy, level);
   endtask

   // Launch one frame, then scramble the inputs and pulse data_valid while busy
   task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt, input logic [5:0] ps);
      frame_t f;
      waitBusy(1'b0, "idle_timeout");
      p_data     = data;
      par_en     = pe;
      par_typ    = pt;
      prescale   = ps;
      data_valid = 1'b1;
      f.data = data;
      f.pe   = pe;
      f.pt   = pt;
      f.p    = (ps == 6'd0) ? 1 : int'(ps);
      expQ.push_back(f);
      framesLaunched++;
      @(negedge clk);
      p_data   = 8'($urandom);
      par_en   = 1'($urandom);
      par_typ  = 1'($urandom);
      prescale = 6'($urandom);
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic waitDrained();
      int n;
      n = 0;
      while (framesDone != framesLaunched && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", framesDone, framesLaunched);
   endtask

   // Line monitor: on busy rising, pop the expected frame and check every cycle
   initial begin
      frame_t      cur;
      logic [10:0] bits;
      int          nbits;
      logic        aborted;
      logic        busyPrev;
      busyPrev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && busy && !busyPrev) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_frame", 32'd1, 32'd0);
            end else begin
               cur  = expQ.pop_front();
               bits = '1;
               bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) bits[1+i] = cur.data[i];
               if (cur.pe) bits[9] = (^cur.data) ^ cur.pt;
               nbits   = cur.pe ? 11 : 10;
               aborted = 1'b0;
               for (int b = 0; b < nbits && !aborted; b++) begin
                  for (int c = 0; c < cur.p && !aborted; c++) begin
                     if (!(b == 0 && c == 0)) @(negedge clk);
                     if (rst) begin
                        aborted = 1'b1;
                     end else begin
                        checkOutput($sformatf("d%02h_bit%0d", cur.data, b), tx_out, bits[b]);
                        checkOutput("busy_in_frame", busy, 1'b1);
                     end
                  end
               end
               if (!aborted) begin
                  @(negedge clk);
                  if (!rst) begin
                     checkOutput("busy_end", busy, 1'b0);
                     checkOutput("line_idle", tx_out, 1'b1);
                  end
               end
               framesDone++;
            end
         end
         busyPrev = busy;
      end
   end

   initial begin
      checkCount     = 0;
      failCount      = 0;
      framesLaunched = 0;
      framesDone     = 0;
      rst        = 1'b1;
      p_data     = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      prescale   = 6'd8;
      #1;
      checkOutput("reset_tx", tx_out, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_tx", tx_out, 1'b1);
      checkOutput("post_reset_busy", busy, 1'b0);

      // Directed frames: plain, both parities, prescale 1 and 0
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8);
      applyStimulus(8'h03, 1'b1, 1'b0, 6'd16);
      applyStimulus(8'h03, 1'b1, 1'b1, 6'd16);
      applyStimulus(8'h07, 1'b1, 1'b0, 6'd1);
      applyStimulus(8'h07, 1'b1, 1'b0, 6'd0);
      waitDrained();

      // data_valid held: second frame must follow one idle cycle later with new data
      begin
         frame_t f;
         p_data     = 8'hA5;
         par_en     = 1'b0;
         par_typ    = 1'b0;
         prescale   = 6'd3;
         data_valid = 1'b1;
         f.data = 8'hA5; f.pe = 1'b0; f.pt = 1'b0; f.p = 3;
         expQ.push_back(f);
         framesLaunched++;
         waitBusy(1'b1, "held_start_timeout");
         p_data = 8'h3C;
         f.data = 8'h3C;
         expQ.push_back(f);
         framesLaunched++;
         waitBusy(1'b0, "held_end_timeout");
         @(negedge clk);
         checkOutput("restart_gap", busy, 1'b1);
         data_valid = 1'b0;
      end
      waitDrained();

      // Asynchronous reset during data bit 4 of an all-ones frame
      applyStimulus(8'hFF, 1'b0, 1'b0, 6'd4);
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_tx", tx_out, 1'b1);
      checkOutput("async_rst_busy", busy, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checkOutput("after_rst_tx", tx_out, 1'b1);
         checkOutput("after_rst_busy", busy, 1'b0);
      end
      waitDrained();

      // Random words with random framing settings
      for (int i = 0; i < 256; i++) begin
         applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 4)));
      end
      waitDrained();
      checkOutput("queue_empty", expQ.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, width of the prescale input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  parallel word to transmit, LSB sent first.
REQ-006 SHALL have port data_valid  input  1  request to send p_data; single-cycle or level.
REQ-007 SHALL have port par_en  input  1  1 = parity bit inserted after data.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port prescale  input  PRESCALE_WIDTH  clk cycles per serial bit.
REQ-010 SHALL have port tx_out  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress, registered.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE with data_valid=1 at edge k, SHALL latch p_data, par_en, par_typ and prescale, and enter START.
REQ-014 tx_out SHALL go 0 and busy 1 from edge k (visible in cycle k+1); no extra latency.
REQ-015 data_valid while busy=1 SHALL be ignored; the in-flight frame and latched values are unaffected by input changes.
REQ-016 Each bit SHALL last exactly P clk cycles, P = latched prescale; prescale=0 SHALL be treated as P=1.
REQ-017 Bit-time counter SHALL count 0..P-1 and wrap to 0 at each bit boundary; the bit counter SHALL count data bits 0..DATA_WIDTH-1.
REQ-018 Transitions: START->DATA after P cycles; DATA->PARITY after DATA_WIDTH bits if par_en latched, else DATA->STOP; PARITY->STOP after P cycles; STOP->IDLE after P cycles.
REQ-019 DATA SHALL drive latched bit i during data bit i, i=0 first.
REQ-020 Parity bit SHALL be XOR of latched data for even, inverted XOR for odd.
REQ-021 STOP SHALL drive tx_out=1; one stop bit only.
REQ-022 Frame length SHALL be (DATA_WIDTH+2+par_en)*P cycles; busy SHALL fall at the same edge the frame ends.
REQ-023 FSM SHALL spend at least one cycle in IDLE between frames; data_valid held high SHALL start the next frame one cycle after busy falls.
REQ-024 In IDLE tx_out SHALL be 1 and busy 0.
REQ-025 Unreachable state encodings SHALL return to IDLE next edge with tx_out=1.

Reset
REQ-026 rst=1 SHALL immediately (no clock) force IDLE, tx_out=1, busy=0, and clear all counters and latched registers.
REQ-027 rst asserted mid-frame SHALL abort the frame; no partial resumption after release.
REQ-028 First frame after rst release SHALL require a new data_valid sampled with rst=0.

Verification
REQ-029 p_data=8'hA5, par_en=0, prescale=8, one-cycle data_valid -> tx_out 0,1,0,1,0,0,1,0,1,1 each 8 cycles; busy high exactly 80 cycles.
REQ-030 p_data=8'h03, par_en=1, par_typ=0, prescale=16 -> parity bit 0, 11 bits, busy 176 cycles; par_typ=1 -> parity bit 1.
REQ-031 p_data=8'h07, par_en=1, par_typ=0, prescale=1 -> parity 1, one bit per clk, busy 11 cycles; prescale=0 gives identical waveform.
REQ-032 data_valid held high, p_data changed to 8'h3C mid-frame -> first frame unchanged; second frame starts one cycle after busy falls carrying 8'h3C.
REQ-033 rst pulsed during data bit 4 of 8'hFF frame -> tx_out=1, busy=0 asynchronously; line stays high until next data_valid.
REQ-034 Loopback: tx_out into the team's UART receiver with matching prescale/par_en/par_typ, 256 random words -> every word received, data_valid each frame, no parity_error or stop_error.
